// File: rtl/mac_frame_scheduler.sv
// Frame-job FIFO and sequencer for mac_frame_generator. Push to start is 3 edges; o_req_ready drops when the FIFO is full.
// Define MAC_SCHED_TIMEOUT_EN to add the WAIT_DONE watchdog, which drops the frame and pulses o_timeout.

module mac_sched_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_dat,
  input  logic          rd_en,
  output logic [W-1:0]  rd_dat,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign full   = (level == LW'(DEPTH));
  assign empty  = (level == '0);
  assign do_wr  = wr_en && !full;
  assign do_rd  = rd_en && !empty;
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

module mac_frame_scheduler #(
  parameter int PAYLOAD_MAX_SIZE = 1500,
  parameter int FIFO_DEPTH       = 8,
  parameter int IFG_CYCLES       = 12,
  parameter int RESEED_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES   = 4096,
  localparam int LW              = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          i_rst_n,
  input  logic          i_enable,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic [15:0]   i_req_length,
  input  logic [7:0]    i_req_mode,
  input  logic          i_req_reseed,
  output logic          o_gen_start,
  output logic [15:0]   o_gen_payload_length,
  output logic [7:0]    o_gen_mode,
  output logic          o_gen_prbs_rst_n,
  input  logic          i_gen_done,
  output logic          o_busy,
  output logic [LW-1:0] o_fifo_level,
  output logic [31:0]   o_frame_cnt,
  output logic          o_len_err,
  output logic          o_timeout
);
  localparam int CNT_MAX_A = (IFG_CYCLES > RESEED_CYCLES) ? IFG_CYCLES : RESEED_CYCLES;
  localparam int CNT_MAX   = (TIMEOUT_CYCLES > CNT_MAX_A) ? TIMEOUT_CYCLES : CNT_MAX_A;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  typedef struct packed {
    logic [15:0] len;
    logic [7:0]  mode;
    logic        reseed;
  } job_t;

  typedef enum logic [2:0] {IDLE, RESEED, START, WAIT_DONE, GAP} state_t;

  state_t             state;
  state_t             state_nxt;
  job_t               push_job;
  job_t               head_job;
  logic               run_q;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               done_q;
  logic               done_edge;
  logic               frame_done;
  logic               clamp;
  logic [15:0]        len_clamped;
  logic [CNT_W-1:0]   cyc_cnt;
  logic [CNT_W-1:0]   cyc_cnt_nxt;
`ifdef MAC_SCHED_TIMEOUT_EN
  logic               wd_expired;
  logic               timeout_q;
`endif

  assign push_job    = '{len: i_req_length, mode: i_req_mode, reseed: i_req_reseed};
  assign o_req_ready = run_q && !fifo_full;
  assign push        = i_req_valid && o_req_ready;
  assign done_edge   = i_gen_done && !done_q;
  assign clamp       = (head_job.len > 16'(PAYLOAD_MAX_SIZE));
  assign len_clamped = clamp ? 16'(PAYLOAD_MAX_SIZE) : head_job.len;
  assign o_busy      = (state != IDLE);

  mac_sched_fifo #(
    .W     ($bits(job_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_job_fifo (
    .clk    (clk),
    .rst_n  (i_rst_n),
    .wr_en  (push),
    .wr_dat (push_job),
    .rd_en  (pop),
    .rd_dat (head_job),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (o_fifo_level)
  );

  always_comb begin
    state_nxt   = state;
    cyc_cnt_nxt = cyc_cnt;
    pop         = 1'b0;
    frame_done  = 1'b0;
`ifdef MAC_SCHED_TIMEOUT_EN
    wd_expired  = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        cyc_cnt_nxt = '0;
        if (i_enable && !fifo_empty) begin
          pop       = 1'b1;
          state_nxt = head_job.reseed ? RESEED : START;
        end
      end
      RESEED: begin
        if (cyc_cnt == CNT_W'(RESEED_CYCLES - 1)) begin
          state_nxt   = START;
          cyc_cnt_nxt = '0;
        end else begin
          cyc_cnt_nxt = cyc_cnt + CNT_W'(1);
        end
      end
      START: begin
        state_nxt   = WAIT_DONE;
        cyc_cnt_nxt = '0;
      end
      WAIT_DONE: begin
        if (done_edge) begin
          frame_done  = 1'b1;
          state_nxt   = (IFG_CYCLES == 0) ? IDLE : GAP;
          cyc_cnt_nxt = '0;
        end
`ifdef MAC_SCHED_TIMEOUT_EN
        else if (cyc_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          wd_expired  = 1'b1;
          state_nxt   = (IFG_CYCLES == 0) ? IDLE : GAP;
          cyc_cnt_nxt = '0;
        end else begin
          cyc_cnt_nxt = cyc_cnt + CNT_W'(1);
        end
`endif
      end
      GAP: begin
        if (cyc_cnt == CNT_W'(IFG_CYCLES - 1)) begin
          state_nxt   = IDLE;
          cyc_cnt_nxt = '0;
        end else begin
          cyc_cnt_nxt = cyc_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Generator-facing strobes lag the state by one edge, so PRBS reset ends right before the start pulse.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state                <= IDLE;
      cyc_cnt              <= '0;
      run_q                <= 1'b0;
      done_q               <= 1'b0;
      o_gen_start          <= 1'b0;
      o_gen_payload_length <= '0;
      o_gen_mode           <= '0;
      o_gen_prbs_rst_n     <= 1'b0;
      o_frame_cnt          <= '0;
      o_len_err            <= 1'b0;
    end else begin
      state            <= state_nxt;
      cyc_cnt          <= cyc_cnt_nxt;
      run_q            <= 1'b1;
      done_q           <= i_gen_done;
      o_gen_start      <= (state == START);
      o_gen_prbs_rst_n <= (state != RESEED);
      o_len_err        <= pop && clamp;
      if (pop) begin
        o_gen_payload_length <= len_clamped;
        o_gen_mode           <= head_job.mode;
      end
      if (frame_done) o_frame_cnt <= o_frame_cnt + 32'd1;
    end
  end

`ifdef MAC_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) timeout_q <= 1'b0;
    else          timeout_q <= wd_expired;
  end
  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif
endmodule
